// File: rtl/faux_host_command_layer.sv
// faux_host_command_layer
//   Simulation-side SATA host command initiator. Accepts a DMA READ/WRITE EXT
//   request, sends the H2D register FIS, supplies pattern write data per DMA
//   Activate or checks incoming read data, then waits for the D2H status FIS
//   and reports done/error.
//
//   Optional build macro: FAUX_HOST_DATA_CHECK_EN
//     defined   : read dwords are compared against the pattern; mismatches are
//                 counted (saturating) and force cmd_error.
//     undefined : no data compare, mismatch_count stays 0.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_stb/cmd_write/cmd_lba/cmd_sector_count   command request (cmd_ready)
//   cmd_done/cmd_error/cmd_status completion report, mismatch_count
//   transport_layer_ready         transport idle
//   send_h2d_reg_stb/send_data_stb, h2d_*   requests to the transport
//   d2h_reg_stb/d2h_status        received D2H register FIS
//   dma_activate_stb              received DMA Activate
//   tl_of_strobe/tl_of_data/tl_of_size       write data pull interface
//   tl_if_strobe/tl_if_data       read data push interface
//   xmit_error, read_crc_fail     transport failures
module faux_host_command_layer #(
    parameter int SECTOR_DWORDS    = 128,
    parameter int DMA_CHUNK_DWORDS = 2048,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_stb,
    input  logic        cmd_write,
    input  logic [47:0] cmd_lba,
    input  logic [15:0] cmd_sector_count,
    output logic        cmd_ready,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic [7:0]  cmd_status,
    output logic [15:0] mismatch_count,
    input  logic        transport_layer_ready,
    output logic        send_h2d_reg_stb,
    output logic        send_data_stb,
    output logic [7:0]  h2d_command,
    output logic [47:0] h2d_lba,
    output logic [15:0] h2d_sector_count,
    output logic [7:0]  h2d_device,
    output logic        h2d_cmd_bit,
    input  logic        d2h_reg_stb,
    input  logic [7:0]  d2h_status,
    input  logic        dma_activate_stb,
    input  logic        tl_of_strobe,
    output logic [31:0] tl_of_data,
    output logic [23:0] tl_of_size,
    input  logic        tl_if_strobe,
    input  logic [31:0] tl_if_data,
    input  logic        xmit_error,
    input  logic        read_crc_fail
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [23:0]   CHUNK_MAX  = 24'(DMA_CHUNK_DWORDS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_CMD, S_WAIT_DMA_ACT, S_SEND_DATA,
        S_DATA_BUSY, S_READ_DATA, S_WAIT_STATUS, S_DONE
    } state_t;

    state_t state, state_next;

    logic [23:0]   total_dwords, remaining, index, chunk, pulled;
    logic [23:0]   cmd_total, next_chunk, of_index, read_count_next;
    logic [16:0]   sectors;
    logic [TW-1:0] timer;
    logic          is_write, sticky_err, any_strobe, waiting, timed_out;
    logic          chunk_full, finishing, finish_error, read_miss;

    assign h2d_device  = 8'h40;
    assign h2d_cmd_bit = 1'b1;

    // A sector count of 0 encodes 65536 sectors.
    assign sectors         = (cmd_sector_count == 16'd0) ? 17'h10000 : {1'b0, cmd_sector_count};
    assign cmd_total       = 24'(32'(sectors) * SECTOR_DWORDS);
    assign next_chunk      = (remaining < CHUNK_MAX) ? remaining : CHUNK_MAX;
    assign chunk_full      = (pulled == chunk);
    assign read_count_next = index + 24'(tl_if_strobe);

    // Once the chunk is fully pulled, surplus strobes see the last dword again.
    assign of_index   = (state == S_DATA_BUSY && chunk_full) ? index - 24'd1 : index;
    assign tl_of_data = h2d_lba[31:0] + 32'(of_index);

    assign any_strobe = dma_activate_stb | tl_of_strobe | tl_if_strobe | d2h_reg_stb;
    assign waiting    = (state != S_IDLE) && (state != S_DONE);
    assign timed_out  = waiting && !any_strobe && (timer == TIMER_LAST);
    assign finishing  = (state != S_DONE) && (state_next == S_DONE);

`ifdef FAUX_HOST_DATA_CHECK_EN
    logic [31:0] rd_pattern;
    assign rd_pattern = h2d_lba[31:0] + 32'(index);
    assign read_miss  = (state == S_READ_DATA) && tl_if_strobe && (tl_if_data != rd_pattern);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_count <= '0;
        end else if (state == S_IDLE && cmd_stb) begin
            mismatch_count <= '0;
        end else if (read_miss && mismatch_count != '1) begin
            mismatch_count <= mismatch_count + 16'd1;
        end
    end
`else
    logic unused_read_data;
    assign unused_read_data = ^tl_if_data;
    assign read_miss        = 1'b0;
    assign mismatch_count   = '0;
`endif

    always_comb begin
        finish_error = sticky_err | xmit_error | read_crc_fail | d2h_status[0] | d2h_status[5];
        if (state == S_WAIT_DMA_ACT) finish_error = 1'b1;
        if (state == S_READ_DATA && read_count_next != total_dwords) finish_error = 1'b1;
        if (mismatch_count != '0 || read_miss) finish_error = 1'b1;
        if (timed_out) finish_error = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:         if (cmd_stb) state_next = S_SEND_CMD;
            S_SEND_CMD:     if (transport_layer_ready) state_next = is_write ? S_WAIT_DMA_ACT : S_READ_DATA;
            S_WAIT_DMA_ACT: if (d2h_reg_stb) state_next = S_DONE;
                            else if (dma_activate_stb) state_next = S_SEND_DATA;
            S_SEND_DATA:    if (transport_layer_ready) state_next = S_DATA_BUSY;
            S_DATA_BUSY:    if (chunk_full && transport_layer_ready)
                                state_next = (remaining == chunk) ? S_WAIT_STATUS : S_WAIT_DMA_ACT;
            S_READ_DATA:    if (d2h_reg_stb) state_next = S_DONE;
            S_WAIT_STATUS:  if (d2h_reg_stb) state_next = S_DONE;
            S_DONE:         state_next = S_IDLE;
            default:        state_next = S_IDLE;
        endcase
        // Timeout only fires while nothing else is moving the FSM.
        if (timed_out && state_next == state) state_next = S_DONE;
    end

    // Output logic
    always_comb begin
        cmd_ready        = (state == S_IDLE);
        cmd_done         = (state == S_DONE);
        send_h2d_reg_stb = (state == S_SEND_CMD) && transport_layer_ready;
        send_data_stb    = (state == S_SEND_DATA) && transport_layer_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || state_next != state || any_strobe || !waiting) timer <= '0;
        else                                                       timer <= timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_write         <= 1'b0;
            h2d_command      <= '0;
            h2d_lba          <= '0;
            h2d_sector_count <= '0;
            total_dwords     <= '0;
            remaining        <= '0;
            index            <= '0;
            chunk            <= '0;
            pulled           <= '0;
            tl_of_size       <= '0;
            sticky_err       <= 1'b0;
            cmd_error        <= 1'b0;
            cmd_status       <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_stb) begin
                    is_write         <= cmd_write;
                    h2d_command      <= cmd_write ? 8'h35 : 8'h25;
                    h2d_lba          <= cmd_lba;
                    h2d_sector_count <= cmd_sector_count;
                    total_dwords     <= cmd_total;
                    remaining        <= cmd_total;
                    index            <= '0;
                    chunk            <= '0;
                    pulled           <= '0;
                    sticky_err       <= 1'b0;
                end
                S_WAIT_DMA_ACT: begin
                    if (d2h_reg_stb) begin
                        sticky_err <= 1'b1;
                    end else if (dma_activate_stb) begin
                        chunk      <= next_chunk;
                        tl_of_size <= next_chunk;
                        pulled     <= '0;
                    end
                end
                S_DATA_BUSY: begin
                    if (tl_of_strobe) begin
                        if (chunk_full) begin
                            sticky_err <= 1'b1;
                        end else begin
                            index  <= index + 24'd1;
                            pulled <= pulled + 24'd1;
                        end
                    end
                    if (chunk_full && transport_layer_ready) remaining <= remaining - chunk;
                end
                S_READ_DATA: if (tl_if_strobe) index <= index + 24'd1;
                default: ;
            endcase
            if (waiting && (xmit_error || read_crc_fail)) sticky_err <= 1'b1;
            if (finishing) begin
                cmd_error  <= finish_error;
                cmd_status <= timed_out ? 8'h00 : d2h_status;
            end
        end
    end

endmodule

// File: tb/tb_faux_host_command_layer.sv
module tb_faux_host_command_layer;

    localparam int T_OUT = 200;

`ifdef FAUX_HOST_DATA_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_stb = 1'b0, cmd_write = 1'b0;
    logic [47:0] cmd_lba = '0;
    logic [15:0] cmd_sector_count = '0;
    logic        cmd_ready, cmd_done, cmd_error;
    logic [7:0]  cmd_status;
    logic [15:0] mismatch_count;
    logic        transport_layer_ready = 1'b1;
    logic        send_h2d_reg_stb, send_data_stb;
    logic [7:0]  h2d_command, h2d_device;
    logic [47:0] h2d_lba;
    logic [15:0] h2d_sector_count;
    logic        h2d_cmd_bit;
    logic        d2h_reg_stb = 1'b0;
    logic [7:0]  d2h_status = '0;
    logic        dma_activate_stb = 1'b0;
    logic        tl_of_strobe = 1'b0;
    logic [31:0] tl_of_data;
    logic [23:0] tl_of_size;
    logic        tl_if_strobe = 1'b0;
    logic [31:0] tl_if_data = '0;
    logic        xmit_error = 1'b0, read_crc_fail = 1'b0;

    always #5 clk = ~clk;

    faux_host_command_layer #(
        .SECTOR_DWORDS(128),
        .DMA_CHUNK_DWORDS(2048),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_stb(cmd_stb), .cmd_write(cmd_write), .cmd_lba(cmd_lba),
        .cmd_sector_count(cmd_sector_count), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_status(cmd_status),
        .mismatch_count(mismatch_count), .transport_layer_ready(transport_layer_ready),
        .send_h2d_reg_stb(send_h2d_reg_stb), .send_data_stb(send_data_stb),
        .h2d_command(h2d_command), .h2d_lba(h2d_lba), .h2d_sector_count(h2d_sector_count),
        .h2d_device(h2d_device), .h2d_cmd_bit(h2d_cmd_bit),
        .d2h_reg_stb(d2h_reg_stb), .d2h_status(d2h_status),
        .dma_activate_stb(dma_activate_stb),
        .tl_of_strobe(tl_of_strobe), .tl_of_data(tl_of_data), .tl_of_size(tl_of_size),
        .tl_if_strobe(tl_if_strobe), .tl_if_data(tl_if_data),
        .xmit_error(xmit_error), .read_crc_fail(read_crc_fail)
    );

    typedef struct {
        logic        err;
        logic [7:0]  status;
        logic [15:0] mism;
    } done_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [23:0] exp_size_q[$];
    done_t       exp_done_q[$];

    logic        reg_seen, data_seen, done_seen;
    logic [7:0]  obs_cmd, obs_status;
    logic [47:0] obs_lba;
    logic [15:0] obs_cnt, obs_mism;
    logic [23:0] obs_size;
    logic [31:0] extra_data;
    logic        obs_err;
    int          n_reg, n_data, n_done;

    always @(negedge clk) begin
        if (send_h2d_reg_stb) n_reg++;
        if (send_data_stb)    n_data++;
        if (cmd_done)         n_done++;
    end

    // ---------------- stimulus drivers (observe only, no checking) ----------
    task automatic push_pattern(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    endtask

    task automatic issue_cmd(input logic w, input logic [47:0] lba, input logic [15:0] cnt);
        int k;
        reg_seen = 1'b0; obs_cmd = 'x; obs_lba = 'x; obs_cnt = 'x;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        cmd_write = w; cmd_lba = lba; cmd_sector_count = cnt; cmd_stb = 1'b1;
        @(negedge clk);
        cmd_stb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (send_h2d_reg_stb) begin
                reg_seen = 1'b1; obs_cmd = h2d_command; obs_lba = h2d_lba; obs_cnt = h2d_sector_count;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic device_write_chunk(input logic extra);
        data_seen = 1'b0; obs_size = 'x; extra_data = 'x;
        @(negedge clk); dma_activate_stb = 1'b1;
        @(negedge clk); dma_activate_stb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (send_data_stb) begin data_seen = 1'b1; obs_size = tl_of_size; break; end
            @(negedge clk);
        end
        if (data_seen) begin
            for (int i = 0; i < int'(obs_size); i++) begin
                @(negedge clk);
                got_q.push_back(tl_of_data);
                tl_of_strobe = 1'b1;
            end
            @(negedge clk);
            if (extra) begin
                extra_data = tl_of_data;
                @(negedge clk);
            end
            tl_of_strobe = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic device_read(input logic [31:0] base, input int n, input int bad_idx, input int crc_idx);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tl_if_strobe  = 1'b1;
            tl_if_data    = (base + 32'(i)) ^ ((i == bad_idx) ? 32'h0000_0100 : 32'h0);
            read_crc_fail = (i == crc_idx);
        end
        @(negedge clk);
        tl_if_strobe = 1'b0; read_crc_fail = 1'b0;
    endtask

    task automatic device_status(input logic [7:0] st);
        done_seen = 1'b0; obs_err = 'x; obs_status = 'x; obs_mism = 'x;
        d2h_status = st; d2h_reg_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d2h_reg_stb = 1'b0;
            if (cmd_done) begin
                done_seen = 1'b1; obs_err = cmd_error; obs_status = cmd_status; obs_mism = mismatch_count;
                break;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
        checks++; if ({cmd_done, cmd_error, send_h2d_reg_stb, send_data_stb} !== 4'b0000) begin
            errors++; $display("FAIL rst_strobes got %b want 0000", {cmd_done, cmd_error, send_h2d_reg_stb, send_data_stb}); end
        checks++; if (cmd_status !== 8'h00) begin errors++; $display("FAIL rst_status got %h want 00", cmd_status); end
        checks++; if (mismatch_count !== 16'h0) begin errors++; $display("FAIL rst_mism got %h want 0", mismatch_count); end
        checks++; if ({h2d_command, h2d_lba, h2d_sector_count} !== 72'h0) begin
            errors++; $display("FAIL rst_h2d got %h want 0", {h2d_command, h2d_lba, h2d_sector_count}); end
        checks++; if (tl_of_size !== 24'h0) begin errors++; $display("FAIL rst_size got %h want 0", tl_of_size); end
        checks++; if ({h2d_device, h2d_cmd_bit} !== 9'h081) begin
            errors++; $display("FAIL const_fields got %h want 081", {h2d_device, h2d_cmd_bit}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write(input logic [47:0] lba, input logic [15:0] cnt, input int n_chunks, input logic [7:0] st);
        done_t ed;
        logic [31:0] e, g;
        int total;
        total = ((cnt == 0) ? 65536 : int'(cnt)) * 128;
        n_reg = 0; n_data = 0; n_done = 0;
        got_q.delete();
        push_pattern(lba[31:0], total);
        for (int c = 0; c < n_chunks; c++) exp_size_q.push_back(24'((total - c * 2048 > 2048) ? 2048 : total - c * 2048));
        exp_done_q.push_back('{err: st[0] | st[5], status: st, mism: 16'h0});
        issue_cmd(1'b1, lba, cnt);
        checks++; if (obs_cmd !== 8'h35) begin errors++; $display("FAIL wr_cmd got %h want 35", obs_cmd); end
        checks++; if (obs_lba !== lba) begin errors++; $display("FAIL wr_lba got %h want %h", obs_lba, lba); end
        checks++; if (obs_cnt !== cnt) begin errors++; $display("FAIL wr_count got %h want %h", obs_cnt, cnt); end
        for (int c = 0; c < n_chunks; c++) begin
            device_write_chunk(1'b0);
            checks++;
            if (obs_size !== exp_size_q[0]) begin errors++; $display("FAIL wr_size got %h want %h", obs_size, exp_size_q[0]); end
            void'(exp_size_q.pop_front());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
            checks++; if (g !== e) begin errors++; $display("FAIL wr_data got %h want %h", g, e); end
        end
        device_status(st);
        ed = exp_done_q.pop_front();
        checks++; if (obs_err !== ed.err) begin errors++; $display("FAIL wr_error got %b want %b", obs_err, ed.err); end
        checks++; if (obs_status !== ed.status) begin errors++; $display("FAIL wr_status got %h want %h", obs_status, ed.status); end
        checks++; if ({n_reg, n_data, n_done} !== {32'd1, 32'(n_chunks), 32'd1}) begin
            errors++; $display("FAIL wr_pulses got %0d/%0d/%0d want 1/%0d/1", n_reg, n_data, n_done, n_chunks); end
    endtask

    task automatic test_read(input logic [47:0] lba, input logic [15:0] cnt, input int n_dw,
                             input int bad_idx, input int crc_idx, input logic want_err, input logic [15:0] want_mism);
        done_t ed;
        n_done = 0;
        exp_done_q.push_back('{err: want_err, status: 8'h50, mism: want_mism});
        issue_cmd(1'b0, lba, cnt);
        checks++; if (obs_cmd !== 8'h25) begin errors++; $display("FAIL rd_cmd got %h want 25", obs_cmd); end
        device_read(lba[31:0], n_dw, bad_idx, crc_idx);
        device_status(8'h50);
        ed = exp_done_q.pop_front();
        checks++; if (obs_err !== ed.err) begin errors++; $display("FAIL rd_error got %b want %b", obs_err, ed.err); end
        checks++; if (obs_mism !== ed.mism) begin errors++; $display("FAIL rd_mism got %h want %h", obs_mism, ed.mism); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL rd_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_extra_strobe();
        exp_done_q.push_back('{err: 1'b1, status: 8'h50, mism: 16'h0});
        issue_cmd(1'b1, 48'h200, 16'd1);
        got_q.delete();
        device_write_chunk(1'b1);
        checks++; if (extra_data !== 32'h0000_027F) begin errors++; $display("FAIL extra_hold got %h want 0000027f", extra_data); end
        device_status(8'h50);
        checks++; if (obs_err !== exp_done_q[0].err) begin errors++; $display("FAIL extra_error got %b want 1", obs_err); end
        void'(exp_done_q.pop_front());
    endtask

    task automatic test_busy_ignore();
        n_reg = 0;
        issue_cmd(1'b1, 48'h300, 16'd1);
        cmd_write = 1'b0; cmd_lba = 48'hDEAD; cmd_sector_count = 16'd5; cmd_stb = 1'b1;
        @(negedge clk);
        cmd_stb = 1'b0;
        checks++; if ({h2d_command, h2d_lba} !== {8'h35, 48'h300}) begin
            errors++; $display("FAIL busy_fields got %h want %h", {h2d_command, h2d_lba}, {8'h35, 48'h300}); end
        got_q.delete();
        device_write_chunk(1'b0);
        checks++; if (got_q.size() !== 128 || got_q[0] !== 32'h300) begin
            errors++; $display("FAIL busy_data got %0d/%h want 128/00000300", got_q.size(), got_q[0]); end
        device_status(8'h50);
        checks++; if ({obs_err, n_reg} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL busy_done got err %b regs %0d want 0 1", obs_err, n_reg); end
    endtask

    task automatic test_timeout();
        int cyc;
        issue_cmd(1'b1, 48'h400, 16'd1);
        checks++; if (reg_seen !== 1'b1) begin errors++; $display("FAIL to_reg got %b want 1", reg_seen); end
        // Edge after the pulse enters WAIT_DMA_ACT; TIMEOUT_CYCLES idle cycles there, then the done cycle.
        cyc = 0; done_seen = 1'b0; obs_err = 'x; obs_status = 'x;
        for (int i = 0; i < T_OUT + 50; i++) begin
            @(negedge clk);
            cyc++;
            if (cmd_done) begin done_seen = 1'b1; obs_err = cmd_error; obs_status = cmd_status; break; end
        end
        checks++; if (cyc !== T_OUT + 1 || done_seen !== 1'b1) begin
            errors++; $display("FAIL to_latency got %0d seen %b want %0d", cyc, done_seen, T_OUT + 1); end
        checks++; if ({obs_err, obs_status} !== 9'h100) begin
            errors++; $display("FAIL to_result got %b/%h want 1/00", obs_err, obs_status); end
        @(negedge clk);
    endtask

    task automatic test_idle_and_abort();
        n_done = 0;
        d2h_status = 8'h51; d2h_reg_stb = 1'b1;
        @(negedge clk);
        d2h_reg_stb = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({n_done, cmd_ready} !== {32'd0, 1'b1}) begin
            errors++; $display("FAIL idle_d2h got done %0d ready %b want 0 1", n_done, cmd_ready); end
        issue_cmd(1'b1, 48'h500, 16'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if ({n_done, cmd_ready, h2d_command} !== {32'd0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL abort got done %0d ready %b cmd %h want 0 1 00", n_done, cmd_ready, h2d_command); end
    endtask

    initial begin
        test_reset();
        test_write(48'h10, 16'd1, 1, 8'h50);
        test_write(48'h1234_FFFF_F000, 16'd40, 3, 8'h50);
        test_write(48'h20, 16'd1, 1, 8'h51);
        test_write(48'h30, 16'd1, 1, 8'h70);
        test_read(48'h0, 16'd2, 256, -1, -1, 1'b0, 16'h0);
        test_read(48'h1000, 16'd1, 128, 5, -1, CHECK_EN, CHECK_EN ? 16'd1 : 16'd0);
        test_read(48'h2000, 16'd1, 128, -1, 40, 1'b1, 16'h0);
        test_read(48'h3000, 16'd1, 127, -1, -1, 1'b1, 16'h0);
        test_extra_strobe();
        test_busy_ignore();
        test_timeout();
        test_idle_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/faux_host_command_layer.md
Name: faux_host_command_layer

Overview:
Simulation-side SATA host command initiator, the host-end counterpart of the faux HD command layer.
- Accepts a DMA read/write request from the testbench.
- Issues the H2D register FIS, then for writes supplies pattern data per DMA Activate, and for reads consumes and checks data FISes.
- Waits for the D2H status register and reports done/error.
- Sits above the host transport layer in host-side and loopback testbenches.

Parameters:
SECTOR_DWORDS, 128, dwords per sector (512 B)
DMA_CHUNK_DWORDS, 2048, max dwords per DMA Activate / data FIS (8 KB)
TIMEOUT_CYCLES, 4096, idle cycles in any wait state before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_stb  in  1  start command; accepted only when cmd_ready=1
cmd_write  in  1  1=DMA WRITE EXT (0x35), 0=DMA READ EXT (0x25)
cmd_lba  in  48  starting LBA; low 32 bits also seed data pattern
cmd_sector_count  in  16  sectors; 0 means 65536
cmd_ready  out  1  high in IDLE
cmd_done  out  1  one-cycle pulse at completion
cmd_error  out  1  valid with cmd_done
cmd_status  out  8  captured D2H status
mismatch_count  out  16  read-data compare failures, saturating
transport_layer_ready  in  1  transport idle
send_h2d_reg_stb  out  1  pulse: send register FIS
send_data_stb  out  1  pulse: send data FIS
h2d_command  out  8  FIS command
h2d_lba  out  48  FIS LBA
h2d_sector_count  out  16  FIS sector count
h2d_device  out  8  constant 0x40
h2d_cmd_bit  out  1  constant 1
d2h_reg_stb  in  1  D2H register FIS received
d2h_status  in  8  status of that FIS
dma_activate_stb  in  1  DMA Activate received
tl_of_strobe  in  1  transport pulls one write dword
tl_of_data  out  32  write dword (combinational from counter)
tl_of_size  out  24  dwords in current data FIS
tl_if_strobe  in  1  transport delivers one read dword
tl_if_data  in  32  read dword
xmit_error  in  1  transport send failure
read_crc_fail  in  1  received FIS CRC failure

Behaviour:
- Reset: IDLE; all strobes 0, cmd_done 0, cmd_error 0, cmd_status 0x00, mismatch_count 0, h2d_command 0, h2d_lba 0, h2d_sector_count 0, tl_of_size 0, all counters 0.
- total_dwords (24 bit) = sectors*SECTOR_DWORDS; sector count 0 gives 65536*128 = 0x800000.
- Pattern: dword i = cmd_lba[31:0] + i, mod 2^32; i counts across the whole command.
- IDLE: on cmd_stb, latch cmd fields, drive h2d_* fields, clear mismatch_count and index, go to SEND_CMD. cmd_stb in any other state is ignored.
- SEND_CMD: when transport_layer_ready, pulse send_h2d_reg_stb for 1 cycle. Write goes to WAIT_DMA_ACT; read goes to READ_DATA.
- WAIT_DMA_ACT: on dma_activate_stb, set chunk = min(remaining, DMA_CHUNK_DWORDS), tl_of_size = chunk, go to SEND_DATA.
- SEND_DATA: when transport_layer_ready, pulse send_data_stb, go to DATA_BUSY.
- DATA_BUSY: each tl_of_strobe advances the index. Once chunk dwords have been pulled and transport_layer_ready=1, remaining -= chunk. If remaining = 0 go to WAIT_STATUS, else WAIT_DMA_ACT.
  - tl_of_strobe beyond chunk: tl_of_data holds the last value; the extra strobe is flagged as an error.
- READ_DATA: each tl_if_strobe compares against the pattern and advances the index. d2h_reg_stb finishes the command; a received count different from total_dwords is an error.
- WAIT_STATUS: d2h_reg_stb captures d2h_status and finishes the command.
- Finish: pulse cmd_done one cycle, return to IDLE next cycle. cmd_error = status[0] (ERR) | status[5] (DF) | sticky error.
- Sticky error is set by xmit_error, read_crc_fail, an early d2h_reg_stb in WAIT_DMA_ACT, or timeout.
- Timeout: counter reset on any input strobe; reaching TIMEOUT_CYCLES in a wait state gives cmd_done=1, cmd_error=1, cmd_status=0x00.
- d2h_reg_stb in IDLE (e.g. power-up diagnostics) is ignored.
- rst mid-command aborts immediately with no cmd_done.

Optional Feature:
FAUX_HOST_DATA_CHECK_EN:
- Defined: read dwords are compared to the pattern; mismatches increment mismatch_count (saturates at 0xFFFF), and a nonzero count sets cmd_error.
- Undefined: no compare, mismatch_count is held 0; the dword count check remains.

Test Plan:
- Write, lba=0x10, count=1 → 1 reg pulse with h2d_command=0x35; 1 DMA act → tl_of_size=128, data 0x10..0x8F; status 0x50 → cmd_done, cmd_error=0.
- Write, count=40 (5120 dwords) → 3 DMA acts with tl_of_size 2048, 2048, 1024; exactly one send_data_stb per act.
- Read, lba=0, count=2 → h2d_command=0x25; 256 correct dwords then status 0x50 → error 0, mismatch_count 0.
- Read with dword 5 corrupted (check enabled) → mismatch_count=1, cmd_error=1; check disabled → mismatch_count=0, cmd_error=0.
- Write where the device never sends a DMA Activate → cmd_done with cmd_error=1 exactly TIMEOUT_CYCLES after the last strobe.
- Status 0x51 returned, or read_crc_fail pulsed mid-read → cmd_error=1; a cmd_stb asserted while busy is ignored.
